// File: rtl/addrc_line_server.sv
// addrc_line_server: operand/result line store for the adder-test file protocol.
// Optional duplicate-write detection is enabled by defining ADDRC_DUP_CHECK_EN.
module addrc_line_server #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [5:0]       load_idx,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic             pass_start,
  input  logic             rd_req,
  input  logic [5:0]       rd_idx,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b,
  input  logic             wr_req,
  input  logic [5:0]       wr_idx,
  input  logic [WIDTH-1:0] wr_sum,
  input  logic             wr_cout,
  output logic             pass_done,
  input  logic             drain_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_idx,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic             err_dup
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [6:0] LINES = 7'd64;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_ops [64];
  logic [WIDTH:0]     r_res [64];
  logic [6:0]         r_cnt;
  logic               r_rd_valid;
  logic [WIDTH-1:0]   r_rd_a;
  logic [WIDTH-1:0]   r_rd_b;
  logic               r_pass_done;
  logic               r_out_valid;
  logic [5:0]         r_out_idx;

  logic               w_load_acc;
  logic               w_rd_acc;
  logic               w_wr_open;
  logic               w_wr_acc;
  logic               w_beat;
  logic [2*WIDTH-1:0] w_rd_word;
  logic [WIDTH:0]     w_out_word;

`ifdef ADDRC_DUP_CHECK_EN
  logic [63:0]        r_mask;
  logic               r_err_dup;
  logic               w_wr_dup;

  assign w_wr_dup = w_wr_open && r_mask[wr_idx];
  assign w_wr_acc = w_wr_open && !r_mask[wr_idx];
  assign err_dup  = r_err_dup;
`else
  assign w_wr_acc = w_wr_open;
  assign err_dup  = 1'b0;
`endif

  assign w_load_acc = (r_state == ST_IDLE) && load_en;
  assign w_rd_acc   = (r_state == ST_SERVE) && rd_req;
  // Writes close once 64 have been counted, even while SERVE lingers one cycle.
  assign w_wr_open  = (r_state == ST_SERVE) && wr_req && (r_cnt != LINES);
  assign w_beat     = (r_state == ST_DRAIN) && r_out_valid && out_ready;

  assign w_rd_word  = r_ops[rd_idx];
  assign w_out_word = r_res[r_out_idx];

  // NOTE: the line memories have no reset so they stay plain register arrays
  // and keep their contents across a reset that aborts a pass or drain.
  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      r_ops[load_idx] <= {load_a, load_b};
    end
    if (w_wr_acc) begin
      r_res[wr_idx] <= {wr_cout, wr_sum};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_a      <= '0;
      r_rd_b      <= '0;
      r_pass_done <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
`ifdef ADDRC_DUP_CHECK_EN
      r_mask      <= '0;
      r_err_dup   <= 1'b0;
`endif
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_a <= w_rd_word[2*WIDTH-1:WIDTH];
        r_rd_b <= w_rd_word[WIDTH-1:0];
      end

      unique case (r_state)
        ST_IDLE: begin
          if (pass_start) begin
            r_cnt       <= '0;
            r_pass_done <= 1'b0;
`ifdef ADDRC_DUP_CHECK_EN
            r_mask      <= '0;
            r_err_dup   <= 1'b0;
`endif
            r_state     <= ST_SERVE;
          end else if (drain_start) begin
            r_out_idx   <= '0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DRAIN;
          end
        end

        ST_SERVE: begin
          if (w_wr_acc) begin
            r_cnt <= r_cnt + 7'd1;
            if (r_cnt == LINES - 7'd1) begin
              r_pass_done <= 1'b1;
            end
`ifdef ADDRC_DUP_CHECK_EN
            r_mask[wr_idx] <= 1'b1;
`endif
          end
`ifdef ADDRC_DUP_CHECK_EN
          if (w_wr_dup) begin
            r_err_dup <= 1'b1;
          end
`endif
          if (r_cnt == LINES) begin
            r_state <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (w_beat) begin
            if (r_out_idx == 6'd63) begin
              r_out_idx   <= '0;
              r_out_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_out_idx <= r_out_idx + 6'd1;
            end
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rd_valid  = r_rd_valid;
  assign rd_a      = r_rd_a;
  assign rd_b      = r_rd_b;
  assign pass_done = r_pass_done;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_sum   = w_out_word[WIDTH-1:0];
  assign out_cout  = w_out_word[WIDTH];
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_addrc_line_server.sv
// Directed self-checking bench for addrc_line_server: load/read, write pass,
// drain with back-pressure, reset mid-drain, start collision, duplicate writes.
module tb_addrc_line_server;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             load_en;
  logic [5:0]       load_idx;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic             pass_start;
  logic             rd_req;
  logic [5:0]       rd_idx;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             wr_req;
  logic [5:0]       wr_idx;
  logic [WIDTH-1:0] wr_sum;
  logic             wr_cout;
  logic             pass_done;
  logic             drain_start;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_idx;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
  logic             err_dup;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] exp_sum  [64];
  logic             exp_cout [64];

  addrc_line_server #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_idx(load_idx), .load_a(load_a), .load_b(load_b),
    .pass_start(pass_start),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_a(rd_a), .rd_b(rd_b),
    .wr_req(wr_req), .wr_idx(wr_idx), .wr_sum(wr_sum), .wr_cout(wr_cout),
    .pass_done(pass_done), .drain_start(drain_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy), .err_dup(err_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_en = 0; load_idx = 0; load_a = 0; load_b = 0;
    pass_start = 0; rd_req = 0; rd_idx = 0; wr_req = 0; wr_idx = 0;
    wr_sum = 0; wr_cout = 0; drain_start = 0; out_ready = 0;
    #12;
    n_cmp++;
    if ({rd_valid, pass_done, out_valid, busy, err_dup, out_idx, rd_a, rd_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got rv=%b pd=%b ov=%b busy=%b dup=%b idx=%0d a=%h b=%h, need all 0",
               rd_valid, pass_done, out_valid, busy, err_dup, out_idx, rd_a, rd_b);
    end
    rst_n = 1'b1;
    tick();
    // requests outside SERVE are dropped
    rd_req = 1; rd_idx = 6'd3; wr_req = 1; wr_idx = 6'd3;
    tick();
    rd_req = 0; wr_req = 0;
    n_cmp++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_drop: got rd_valid=%b busy=%b, need 0 0", rd_valid, busy);
    end
  endtask

  task automatic test_load_read();
    for (int i = 0; i < 64; i++) begin
      load_en = 1; load_idx = 6'(i); load_a = WIDTH'(i); load_b = WIDTH'(2 * i);
      tick();
    end
    load_en = 0;
    pass_start = 1;
    tick();
    pass_start = 0;
    n_cmp++;
    if (busy !== 1'b1 || pass_done !== 1'b0) begin
      n_bad++;
      $display("FAIL pass_entry: got busy=%b pass_done=%b, need 1 0", busy, pass_done);
    end
    load_en = 1; load_idx = 6'd5; load_a = 32'hdead_beef; load_b = 32'hdead_beef;
    tick();
    load_en = 0;
    rd_req = 1; rd_idx = 6'd5;
    tick();
    rd_req = 0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_a !== 32'd5 || rd_b !== 32'd10) begin
      n_bad++;
      $display("FAIL read_idx5: got v=%b a=%0d b=%0d, need 1 5 10", rd_valid, rd_a, rd_b);
    end
    tick();
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_a !== 32'd5 || rd_b !== 32'd10) begin
      n_bad++;
      $display("FAIL read_hold: got v=%b a=%0d b=%0d, need 0 5 10", rd_valid, rd_a, rd_b);
    end
  endtask

  task automatic test_write_pass();
    for (int k = 0; k < 64; k++) begin
      wr_req = 1; wr_idx = 6'(k); wr_sum = WIDTH'(3 * k); wr_cout = k[0];
      exp_sum[k] = WIDTH'(3 * k); exp_cout[k] = k[0];
      rd_req = (k == 10); rd_idx = 6'd63;
      tick();
      rd_req = 0;
      if (k == 10) begin
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_a !== 32'd63 || rd_b !== 32'd126) begin
          n_bad++;
          $display("FAIL read_with_write: got v=%b a=%0d b=%0d, need 1 63 126", rd_valid, rd_a, rd_b);
        end
      end
      if (k == 62) begin
        n_cmp++;
        if (pass_done !== 1'b0) begin
          n_bad++;
          $display("FAIL pass_done_early: got %b after 63 writes, need 0", pass_done);
        end
      end
      if (k == 63) begin
        n_cmp++;
        if (pass_done !== 1'b1 || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL pass_done_edge: got pd=%b busy=%b, need 1 1", pass_done, busy);
        end
      end
    end
    // extra write after the 64th is dropped
    wr_req = 1; wr_idx = 6'd0; wr_sum = 32'd999; wr_cout = 1;
    tick();
    wr_req = 0;
    n_cmp++;
    if (busy !== 1'b0 || pass_done !== 1'b1) begin
      n_bad++;
      $display("FAIL pass_exit: got busy=%b pd=%b, need 0 1", busy, pass_done);
    end
    tick();
    n_cmp++;
    if (pass_done !== 1'b1) begin
      n_bad++;
      $display("FAIL pass_done_sticky: got %b, need 1", pass_done);
    end
  endtask

  // mode 0: out_ready held high; mode 1: out_ready toggles 1,0,1,...
  // stop < 64 returns right after beat index stop-1 has transferred.
  task automatic test_drain(input int mode, input int stop);
    int  exp_i;
    int  c;
    bit  rdy;
    drain_start = 1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_pre_valid: got out_valid=%b, need 0", out_valid);
    end
    tick();
    drain_start = 0;
    exp_i = 0;
    c = 0;
    while (exp_i < 64 && exp_i != stop && c < 400) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 6'(exp_i) || out_sum !== exp_sum[exp_i] ||
          out_cout !== exp_cout[exp_i] || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL drain_beat: got v=%b idx=%0d sum=%0d c=%b busy=%b, need 1 %0d %0d %b 1",
                 out_valid, out_idx, out_sum, out_cout, busy, exp_i, exp_sum[exp_i], exp_cout[exp_i]);
      end
      rdy = (mode == 0) ? 1'b1 : (c % 2 == 0);
      out_ready = rdy;
      tick();
      if (rdy) exp_i++;
      c++;
    end
    out_ready = 0;
    if (c >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats, need 64", exp_i);
    end else if (exp_i == 64) begin
      n_cmp++;
      if (out_valid !== 1'b0 || out_idx !== 6'd0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL drain_end: got v=%b idx=%0d busy=%b, need 0 0 0", out_valid, out_idx, busy);
      end
    end
  endtask

  task automatic test_drain_reset();
    test_drain(0, 20);
    n_cmp++;
    if (out_idx !== 6'd20 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_at20: got idx=%0d v=%b, need 20 1", out_idx, out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_idx !== 6'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b idx=%0d busy=%b, need 0 0 0", out_valid, out_idx, busy);
    end
    #2;
    rst_n = 1'b1;
    tick();
    test_drain(1, 64);
  endtask

  task automatic test_collision_dup();
    int cnt;
    pass_start = 1; drain_start = 1;
    tick();
    pass_start = 0; drain_start = 0;
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || pass_done !== 1'b0) begin
      n_bad++;
      $display("FAIL start_collision: got busy=%b ov=%b pd=%b, need 1 0 0", busy, out_valid, pass_done);
    end
    rd_req = 1; rd_idx = 6'd63;
    tick();
    rd_req = 0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_a !== 32'd63 || rd_b !== 32'd126) begin
      n_bad++;
      $display("FAIL collision_serve: got v=%b a=%0d b=%0d, need 1 63 126", rd_valid, rd_a, rd_b);
    end
    wr_req = 1; wr_idx = 6'd7; wr_sum = 32'd1; wr_cout = 1;
    tick();
    wr_idx = 6'd7; wr_sum = 32'd2; wr_cout = 0;
    tick();
    wr_req = 0;
`ifdef ADDRC_DUP_CHECK_EN
    exp_sum[7] = 32'd1; exp_cout[7] = 1'b1; cnt = 1;
    n_cmp++;
    if (err_dup !== 1'b1) begin
      n_bad++;
      $display("FAIL dup_flag: got err_dup=%b, need 1", err_dup);
    end
`else
    exp_sum[7] = 32'd2; exp_cout[7] = 1'b0; cnt = 2;
    n_cmp++;
    if (err_dup !== 1'b0) begin
      n_bad++;
      $display("FAIL dup_flag: got err_dup=%b, need 0", err_dup);
    end
`endif
    for (int k = 0; k < 64; k++) begin
      if (k == 7) continue;
`ifndef ADDRC_DUP_CHECK_EN
      if (k == 8) continue;
`endif
      wr_req = 1; wr_idx = 6'(k); wr_sum = WIDTH'(3 * k); wr_cout = k[0];
      tick();
      cnt++;
      if (cnt == 63 || cnt == 64) begin
        n_cmp++;
        if (pass_done !== (cnt == 64)) begin
          n_bad++;
          $display("FAIL dup_pass_count: got pass_done=%b at count %0d, need %b",
                   pass_done, cnt, (cnt == 64));
        end
      end
    end
    wr_req = 0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL dup_pass_exit: got busy=%b, need 0", busy);
    end
    test_drain(0, 64);
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_write_pass();
    test_drain(1, 64);
    test_drain_reset();
    test_collision_dup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
